// File: rtl/kb_keymap.sv
// PS/2 set-2 key decoder: tracks N_KEYS keys from one received-byte stream,
// producing held levels, make/break pulses and typematic repeat for the last pressed key.
module kb_keymap #(
  parameter int                  N_KEYS        = 6,
  parameter logic [8*N_KEYS-1:0] KEY_CODES     = {8'h5A, 8'h2D, 8'h1B, 8'h1D, 8'h23, 8'h1C},
  parameter logic [N_KEYS-1:0]   EXT_MASK      = {N_KEYS{1'b0}},
  parameter int                  REPEAT_DELAY  = 50_000_000,
  parameter int                  REPEAT_PERIOD = 5_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scan_done_tick,
  input  logic [7:0]        scan_code,
  output logic [N_KEYS-1:0] key_held,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release
);

  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CW      = $clog2(RPT_MAX);
  localparam int IW      = (N_KEYS > 1) ? $clog2(N_KEYS) : 1;

  localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PERIOD - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXT  = 2'd1;
  localparam logic [1:0] ST_BRK  = 2'd2;

  localparam logic [7:0] BYTE_EXT = 8'hE0;
  localparam logic [7:0] BYTE_BRK = 8'hF0;

  logic [1:0]        state_q, state_d;
  logic              ext_q, ext_d;
  logic [N_KEYS-1:0] held_q, held_d;
  logic [N_KEYS-1:0] press_q, press_d;
  logic [N_KEYS-1:0] release_q, release_d;
  logic              rpt_valid_q, rpt_valid_d;
  logic [IW-1:0]     rpt_idx_q, rpt_idx_d;
  logic              rpt_first_q, rpt_first_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic              do_make;
  logic              do_break;
  logic              code_ext;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d     = state_q;
    ext_d       = ext_q;
    held_d      = held_q;
    press_d     = '0;
    release_d   = '0;
    rpt_valid_d = rpt_valid_q;
    rpt_idx_d   = rpt_idx_q;
    rpt_first_d = rpt_first_q;
    cnt_d       = cnt_q;
    do_make     = 1'b0;
    do_break    = 1'b0;
    code_ext    = 1'b0;

    // Repeat timer; the first interval is the delay, later ones the period.
    if (rpt_valid_q && held_q[rpt_idx_q]) begin
      if (cnt_q == (rpt_first_q ? DLY_LAST : PER_LAST)) begin
        press_d[rpt_idx_q] = 1'b1;
        cnt_d              = '0;
        rpt_first_d        = 1'b0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    if (scan_done_tick) begin
      case (state_q)
        ST_IDLE: begin
          if (scan_code == BYTE_EXT) begin
            state_d = ST_EXT;
          end else if (scan_code == BYTE_BRK) begin
            state_d = ST_BRK;
            ext_d   = 1'b0;
          end else begin
            do_make = 1'b1;
          end
        end
        ST_EXT: begin
          if (scan_code == BYTE_BRK) begin
            state_d = ST_BRK;
            ext_d   = 1'b1;
          end else if (scan_code != BYTE_EXT) begin
            do_make  = 1'b1;
            code_ext = 1'b1;
            state_d  = ST_IDLE;
          end
        end
        ST_BRK: begin
          do_break = 1'b1;
          code_ext = ext_q;
          state_d  = ST_IDLE;
          ext_d    = 1'b0;
        end
        default: begin
          state_d = ST_IDLE;
          ext_d   = 1'b0;
        end
      endcase
    end

    // Descending scan so the lowest newly pressed index ends up owning the repeat.
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (scan_code == KEY_CODES[8*i +: 8] && code_ext == EXT_MASK[i]) begin
        if (do_make && !held_q[i]) begin
          held_d[i]   = 1'b1;
          press_d[i]  = 1'b1;
          rpt_valid_d = 1'b1;
          rpt_idx_d   = IW'(i);
          rpt_first_d = 1'b1;
          cnt_d       = '0;
        end
        if (do_break) begin
          if (held_q[i]) begin
            held_d[i]    = 1'b0;
            release_d[i] = 1'b1;
          end
          if (rpt_valid_q && rpt_idx_q == IW'(i)) begin
            rpt_valid_d = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q     <= ST_IDLE;
      ext_q       <= 1'b0;
      held_q      <= '0;
      press_q     <= '0;
      release_q   <= '0;
      rpt_valid_q <= 1'b0;
      rpt_idx_q   <= '0;
      rpt_first_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      ext_q       <= ext_d;
      held_q      <= held_d;
      press_q     <= press_d;
      release_q   <= release_d;
      rpt_valid_q <= rpt_valid_d;
      rpt_idx_q   <= rpt_idx_d;
      rpt_first_q <= rpt_first_d;
      cnt_q       <= cnt_d;
    end
  end

  assign key_held    = held_q;
  assign key_press   = press_q;
  assign key_release = release_q;

endmodule

// File: tb/tb_kb_keymap.sv
// Directed bench for kb_keymap: a byte/expectation table plus cycle-mapped
// sequences for repeat timing, key overlap, duplicate codes and reset.
module tb_kb_keymap;

  localparam int NK = 6;

  logic          clk   = 1'b0;
  logic          reset = 1'b0;
  logic          tick  = 1'b0;
  logic [7:0]    code  = 8'h00;

  logic [NK-1:0] a_held, a_press, a_rel;
  logic [NK-1:0] x_held, x_press, x_rel;
  logic [NK-1:0] d_held, d_press, d_rel;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  kb_keymap #(
    .N_KEYS(NK), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
  ) u_a (
    .clk(clk), .reset(reset), .scan_done_tick(tick), .scan_code(code),
    .key_held(a_held), .key_press(a_press), .key_release(a_rel)
  );

  kb_keymap #(
    .N_KEYS(NK), .KEY_CODES(48'h5A2D1B1D2375), .EXT_MASK(6'b000001),
    .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
  ) u_x (
    .clk(clk), .reset(reset), .scan_done_tick(tick), .scan_code(code),
    .key_held(x_held), .key_press(x_press), .key_release(x_rel)
  );

  kb_keymap #(
    .N_KEYS(NK), .KEY_CODES(48'h5A2D2D1D231C),
    .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
  ) u_d (
    .clk(clk), .reset(reset), .scan_done_tick(tick), .scan_code(code),
    .key_held(d_held), .key_press(d_press), .key_release(d_rel)
  );

  typedef struct {
    logic [1:0]    dut;    // 0 = default map, 1 = extended map, 2 = duplicate map
    logic          rst;    // reset all DUTs before this byte
    logic [7:0]    code;
    logic [NK-1:0] held;
    logic [NK-1:0] press;
    logic [NK-1:0] rel;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [1:0] d, input logic r, input logic [7:0] c,
                     input logic [NK-1:0] h, input logic [NK-1:0] p, input logic [NK-1:0] rl);
    vec_t v;
    v.dut = d; v.rst = r; v.code = c; v.held = h; v.press = p; v.rel = rl;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Inputs change 1ns after a rising edge; outputs are read at the same point.
  task automatic do_reset();
    reset = 1'b1;
    tick  = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    tick = 1'b1;
    code = b;
    @(posedge clk); #1;
    tick = 1'b0;
  endtask

  logic [NK-1:0]  act_h, act_p, act_r;
  logic [127:0]   bm_a, bm_b, bm_c, exp_a, exp_b, exp_c;

  initial begin
    @(posedge clk); #1;
    do_reset();
    check("reset_a", {a_held, a_press, a_rel}, '0);
    check("reset_x", {x_held, x_press, x_rel}, '0);
    check("reset_d", {d_held, d_press, d_rel}, '0);

    // Default map: make, suppressed resend, prefixes that must not match.
    add(0, 1, 8'h1C, 6'b000001, 6'b000001, 6'b000000);
    add(0, 0, 8'h23, 6'b000011, 6'b000010, 6'b000000);
    add(0, 0, 8'h23, 6'b000011, 6'b000000, 6'b000000);
    add(0, 0, 8'hF0, 6'b000011, 6'b000000, 6'b000000);
    add(0, 0, 8'h23, 6'b000001, 6'b000000, 6'b000010);
    add(0, 0, 8'hE0, 6'b000001, 6'b000000, 6'b000000);
    add(0, 0, 8'h1C, 6'b000001, 6'b000000, 6'b000000);
    add(0, 0, 8'h10, 6'b000001, 6'b000000, 6'b000000);
    add(0, 0, 8'hF0, 6'b000001, 6'b000000, 6'b000000);
    add(0, 0, 8'hE0, 6'b000001, 6'b000000, 6'b000000);
    add(0, 0, 8'hF0, 6'b000001, 6'b000000, 6'b000000);
    add(0, 0, 8'h1C, 6'b000000, 6'b000000, 6'b000001);
    add(0, 0, 8'hF0, 6'b000000, 6'b000000, 6'b000000);
    add(0, 0, 8'hF0, 6'b000000, 6'b000000, 6'b000000);
    add(0, 0, 8'h5A, 6'b100000, 6'b100000, 6'b000000);
    // Extended-only key0 = E0 75.
    add(1, 1, 8'h75, 6'b000000, 6'b000000, 6'b000000);
    add(1, 0, 8'hE0, 6'b000000, 6'b000000, 6'b000000);
    add(1, 0, 8'h75, 6'b000001, 6'b000001, 6'b000000);
    add(1, 0, 8'hE0, 6'b000001, 6'b000000, 6'b000000);
    add(1, 0, 8'hF0, 6'b000001, 6'b000000, 6'b000000);
    add(1, 0, 8'h75, 6'b000000, 6'b000000, 6'b000001);
    add(1, 0, 8'hF0, 6'b000000, 6'b000000, 6'b000000);
    add(1, 0, 8'hE0, 6'b000000, 6'b000000, 6'b000000);
    add(1, 0, 8'h75, 6'b000000, 6'b000000, 6'b000000);
    // Keys 3 and 4 share 2D.
    add(2, 1, 8'h2D, 6'b011000, 6'b011000, 6'b000000);
    add(2, 0, 8'hF0, 6'b011000, 6'b000000, 6'b000000);
    add(2, 0, 8'h2D, 6'b000000, 6'b000000, 6'b011000);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) do_reset();
      send(vecs[i].code);
      case (vecs[i].dut)
        2'd1:    begin act_h = x_held; act_p = x_press; act_r = x_rel; end
        2'd2:    begin act_h = d_held; act_p = d_press; act_r = d_rel; end
        default: begin act_h = a_held; act_p = a_press; act_r = a_rel; end
      endcase
      check($sformatf("vec%0d_held_press_rel", i), {act_h, act_p, act_r},
            {vecs[i].held, vecs[i].press, vecs[i].rel});
    end

    // Press then break 10 cycles later: no repeat may appear.
    do_reset();
    send(8'h1C);
    bm_a = '0; bm_b = '0; bm_c = '0;
    for (int c = 0; c <= 60; c++) begin
      bm_a[c] = a_press[0]; bm_b[c] = a_held[0]; bm_c[c] = a_rel[0];
      tick = (c == 9 || c == 10);
      code = (c == 9) ? 8'hF0 : 8'h1C;
      @(posedge clk); #1;
    end
    tick = 1'b0;
    exp_a = '0; exp_a[0] = 1'b1;
    exp_b = '0; for (int c = 0; c <= 10; c++) exp_b[c] = 1'b1;
    exp_c = '0; exp_c[11] = 1'b1;
    check("tap_press_map", bm_a, exp_a);
    check("tap_held_map", bm_b, exp_b);
    check("tap_release_map", bm_c, exp_c);

    // Hold key1 with a keyboard resend, then break.
    do_reset();
    send(8'h23);
    bm_a = '0; bm_c = '0;
    for (int c = 0; c <= 90; c++) begin
      bm_a[c] = a_press[1]; bm_c[c] = a_rel[1];
      tick = (c == 4 || c == 48 || c == 49);
      code = (c == 48) ? 8'hF0 : 8'h23;
      @(posedge clk); #1;
    end
    tick = 1'b0;
    exp_a = '0; exp_a[0] = 1'b1; exp_a[20] = 1'b1; exp_a[28] = 1'b1; exp_a[36] = 1'b1; exp_a[44] = 1'b1;
    exp_c = '0; exp_c[50] = 1'b1;
    check("hold_press_map", bm_a, exp_a);
    check("hold_release_map", bm_c, exp_c);
    check("hold_other_keys", {a_held, a_press, a_rel}, '0);

    // Overlap: key2 takes repeat ownership from key0.
    do_reset();
    bm_a = '0; bm_b = '0;
    for (int c = 0; c <= 80; c++) begin
      bm_a[c] = a_press[0]; bm_b[c] = a_press[2];
      tick = (c == 0 || c == 3 || c == 41 || c == 42);
      code = (c == 0) ? 8'h1C : (c == 41) ? 8'hF0 : 8'h1D;
      @(posedge clk); #1;
    end
    tick = 1'b0;
    exp_a = '0; exp_a[1] = 1'b1;
    exp_b = '0; exp_b[4] = 1'b1; exp_b[24] = 1'b1; exp_b[32] = 1'b1; exp_b[40] = 1'b1;
    check("overlap_key0_press_map", bm_a, exp_a);
    check("overlap_key2_press_map", bm_b, exp_b);
    check("overlap_held_end", a_held, 6'b000001);

    // Duplicate code: key3 owns the repeat.
    do_reset();
    bm_a = '0; bm_b = '0;
    for (int c = 0; c <= 40; c++) begin
      bm_a[c] = d_press[3]; bm_b[c] = d_press[4];
      tick = (c == 0);
      code = 8'h2D;
      @(posedge clk); #1;
    end
    tick = 1'b0;
    exp_a = '0; exp_a[1] = 1'b1; exp_a[21] = 1'b1; exp_a[29] = 1'b1; exp_a[37] = 1'b1;
    exp_b = '0; exp_b[1] = 1'b1;
    check("dup_key3_press_map", bm_a, exp_a);
    check("dup_key4_press_map", bm_b, exp_b);

    // Reset mid-prefix with a simultaneous tick, then a clean make.
    do_reset();
    send(8'h1C);
    send(8'hE0);
    send(8'hF0);
    reset = 1'b1; tick = 1'b1; code = 8'h1C;
    @(posedge clk); #1;
    reset = 1'b0; tick = 1'b0;
    check("reset_mid_prefix", {a_held, a_press, a_rel}, '0);
    @(posedge clk); #1;
    check("reset_tick_ignored", {a_held, a_press, a_rel}, '0);
    send(8'h1C);
    check("post_reset_make", {a_held, a_press, a_rel}, {6'b000001, 6'b000001, 6'b000000});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/kb_keymap.md
# kb_keymap

Parametrised keyboard key decoder between `ps2_rx` and the game logic. It replaces the per-key `kb_controller` + `blipgen` pairs with one block that tracks N keys from a single received-byte stream. It understands PS/2 set-2 break (F0) and extended (E0) prefixes. It outputs per-key held levels, one-cycle press and release pulses, and a typematic auto-repeat press pulse for the most recently pressed key.

## Interface
- `N_KEYS`, 6: number of key channels, 1..32.
- `KEY_CODES`, {8'h5A,8'h2D,8'h1B,8'h1D,8'h23,8'h1C}: packed 8*N_KEYS scan codes; key i uses bits [8i+7:8i]. The default maps key0=1C, key1=23, key2=1D, key3=1B, key4=2D, key5=5A.
- `EXT_MASK`, {N_KEYS{1'b0}}: bit i=1 means key i matches only E0-prefixed codes; bit i=0 means key i matches only non-prefixed codes.
- `REPEAT_DELAY`, 50_000_000: cycles from first press to the first repeat pulse; must be ≥2.
- `REPEAT_PERIOD`, 5_000_000: cycles between later repeat pulses; must be ≥2.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `scan_done_tick`  in  1  one-cycle strobe; `scan_code` is valid on this cycle.
- `scan_code`  in  8  received byte.
- `key_held`  out  N_KEYS  level; 1 while key i is down.
- `key_press`  out  N_KEYS  one-cycle pulse on make, and on each auto-repeat.
- `key_release`  out  N_KEYS  one-cycle pulse on break.

## Operation
- Prefix FSM, advanced only on cycles with `scan_done_tick`=1. Flag `ext` is kept with the state.
  - IDLE: byte E0 → EXT. Byte F0 → BRK with ext=0. Any other byte → make(byte, ext=0), stay in IDLE.
  - EXT: byte E0 → stay in EXT. Byte F0 → BRK with ext=1. Any other byte → make(byte, ext=1) → IDLE.
  - BRK: any byte, including E0 and F0 → break(byte, ext) → IDLE.
- Match rule: key i matches when byte == KEY_CODES[i] and ext == EXT_MASK[i]. Several keys may share a code; every matching key acts.
- make on key i:
  - If key_held[i]=0: set key_held[i], pulse key_press[i], make i the repeat key, restart the repeat counter.
  - If key_held[i]=1: no output. The keyboard's own typematic resends are suppressed.
- break on key i:
  - If key_held[i]=1: clear key_held[i] and pulse key_release[i].
  - If key_held[i]=0: no output.
  - If i is the repeat key, repeat stops.
- If one make matches several keys, the repeat key is the lowest matching index.
- Auto-repeat:
  - Counter width is clog2(max(REPEAT_DELAY,REPEAT_PERIOD)).
  - The counter runs only while a repeat key is valid and still held.
  - REPEAT_DELAY cycles after the make pulse, pulse key_press[repeat key]. Every REPEAT_PERIOD cycles after that, pulse it again.
- Simultaneous events:
  - A make/break pulse and a repeat pulse for the same key in the same cycle merge into one key_press cycle.
  - A new make for a different key moves repeat ownership to that key. The old key stays held with no repeat.
- Unmatched bytes only move the FSM. They have no effect on outputs.

## Timing
- All outputs are registered.
- key_held, key_press and key_release change on the cycle after the scan_done_tick cycle that completes the make or break, i.e. latency 1.
- Pulses are exactly one cycle wide. Back-to-back scan_done_ticks are legal and each is decoded.
- Repeat pulse timing: if the make pulse is at cycle T, repeat pulses are at T+REPEAT_DELAY, then T+REPEAT_DELAY+k·REPEAT_PERIOD for k=1,2,….
- A break at cycle B clears the repeat. No repeat pulse appears at or after B+1.
- Reset, including mid-prefix or mid-repeat:
  - FSM → IDLE, ext=0, repeat invalid, counter 0.
  - key_held, key_press and key_release all 0 on the cycle after reset is sampled high.
  - A tick in the same cycle as reset is ignored.

## Test plan
- Default params, REPEAT_DELAY=20, REPEAT_PERIOD=8. Send 1C, then F0 1C 10 cycles later → key_press=6'b000001 for 1 cycle; key_held[0]=1 until the break; key_release[0] pulses 1 cycle after the 1C that follows F0. No repeat pulse appears.
- Hold: send 23 at T, then 23 at T+5 → key_press[1] pulses at T+1 only; repeat pulses at T+1+20, then +8 and +16 after that; after F0 23, no further pulses.
- Extended: EXT_MASK bit0=1, KEY_CODES[0]=8'h75. Bytes 75 → no output. Bytes E0 75 → key_press[0]. Bytes E0 F0 75 → key_release[0]. Bytes F0 E0 → FSM returns to IDLE, no output.
- Overlap: send 1C at T, 1D at T+3 → both held; repeat pulses only key2 at T+4+20; break 1D → no repeats for key0.
- Duplicate codes: KEY_CODES[3]=KEY_CODES[4]=8'h2D. Send 2D → key_press=6'b011000; the repeat key is key3.
- Reset: after E0 F0, assert reset for 1 cycle → all outputs 0. Then send 1C → make of key0, not a break.
